// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared defaults for the pipeline control slice
package pipe_ctrl_pkg;

  localparam int PIPE_STAGES_DEFAULT = 5;
  localparam int PIPE_DATA_W_DEFAULT = 64;
  localparam int CNT_W_DEFAULT       = 32;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - fetch-side and retire-side handshakes of the pipeline
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W_DEFAULT
) ();

  // entry side: fetch source offers, stage 0 accepts
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  // retire side: oldest stage presents, consumer accepts
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // pipeline controller view
  modport master (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  // surrounding environment view
  modport slave (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid bit plus payload register of the pipeline
module pipe_stage #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kill,
  input  logic              allow_in,
  input  logic              in_bit,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // reset clears, kill drops the entry but keeps stale payload, otherwise load when open
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (allow_in) begin
      valid <= in_bit;
      if (in_bit) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - in-order pipeline valid/allow_in control with flush and counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = PIPE_STAGES_DEFAULT,
  parameter int DATA_W = PIPE_DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  pipe_ctrl_if.master                   bus,
  input  logic [STAGES-1:0]             stage_over,
  input  logic [STAGES-1:0]             flush_req,
  output logic [STAGES-1:0]             stage_valid,
  output logic [STAGES-1:0]             stage_allow_in,
  output logic [STAGES*DATA_W-1:0]      stage_data,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]              retire_cnt,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  localparam int OCC_W = $clog2(STAGES + 1);

  if (STAGES < 2) begin : g_param_check
    $error("pipe_ctrl: STAGES must be at least 2");
  end

  logic [STAGES-1:0] valid_q;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [STAGES-1:0] allow;
  logic [STAGES-1:0] eff;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] in_bit;
  logic [STAGES-1:0] valid_nxt;
  logic              flush_any;
  logic              in_ready_w;
  logic              out_valid_w;
  logic [OCC_W-1:0]  occ_nxt;

  // readiness ripples from the consumer back to stage 0, oldest first
  always_comb begin
    logic down;
    allow = '0;
    down  = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      allow[i] = ~valid_q[i] | (stage_over[i] & down);
      down     = allow[i];
    end
  end

  // the oldest valid flusher wins; every stage younger than it is killed
  always_comb begin
    logic seen;
    eff  = flush_req & valid_q;
    kill = '0;
    seen = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      kill[i] = seen;
      seen    = seen | eff[i];
    end
    flush_any = seen;
  end

  assign in_ready_w  = allow[0] & ~flush_any;
  assign out_valid_w = valid_q[STAGES-1] & stage_over[STAGES-1];

  // what each stage would receive if it opens; a killed predecessor hands over a bubble
  always_comb begin
    in_bit    = '0;
    in_bit[0] = bus.in_valid & in_ready_w;
    for (int i = 1; i < STAGES; i++) begin
      in_bit[i] = valid_q[i-1] & stage_over[i-1] & ~kill[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [DATA_W-1:0] src;

    if (g == 0) begin : g_head
      assign src = bus.in_data;
    end else begin : g_body
      assign src = data_q[g-1];
    end

    pipe_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .kill     (kill[g]),
      .allow_in (allow[g]),
      .in_bit   (in_bit[g]),
      .in_data  (src),
      .valid    (valid_q[g]),
      .data     (data_q[g])
    );

    assign stage_data[g*DATA_W +: DATA_W] = data_q[g];
  end

  // next-state valid vector, so occupancy can be registered yet track stage_valid exactly
  always_comb begin
    valid_nxt = '0;
    occ_nxt   = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (reset || kill[i]) begin
        valid_nxt[i] = 1'b0;
      end else if (allow[i]) begin
        valid_nxt[i] = in_bit[i];
      end else begin
        valid_nxt[i] = valid_q[i];
      end
      occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
    end
  end

  // occupancy register
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_nxt;
    end
  end

  // performance counters, free-running and wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (out_valid_w && bus.out_ready) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (bus.in_valid && !in_ready_w) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_any) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_w;
  assign bus.out_data   = data_q[STAGES-1];
  assign stage_valid    = valid_q;
  assign stage_allow_in = allow;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed checks of pipe_ctrl against a slot model
module tb_pipe_ctrl;

  localparam int S  = 5;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int OW = $clog2(S + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.DATA_W(DW)) bus ();

  logic [S-1:0]    stage_over;
  logic [S-1:0]    flush_req;
  logic [S-1:0]    stage_valid;
  logic [S-1:0]    stage_allow_in;
  logic [S*DW-1:0] stage_data;
  logic [OW-1:0]   occupancy;
  logic [CW-1:0]   retire_cnt;
  logic [CW-1:0]   stall_cnt;
  logic [CW-1:0]   flush_cnt;

  pipe_ctrl #(
    .STAGES (S),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .stage_over     (stage_over),
    .flush_req      (flush_req),
    .stage_valid    (stage_valid),
    .stage_allow_in (stage_allow_in),
    .stage_data     (stage_data),
    .occupancy      (occupancy),
    .retire_cnt     (retire_cnt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  // reference: S slots, each either empty or holding a payload
  bit            m_v [S];
  logic [DW-1:0] m_d [S];
  logic [CW-1:0] m_ret, m_stl, m_fl;
  bit            checking = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // compare the current cycle against the model, then move the model across the edge
  task automatic step();
    int            kmax;
    bit            take [S+1];
    bit            e_in_ready, e_out_valid, incoming;
    logic [S-1:0]  e_sv, e_ai;
    logic [S*DW-1:0] e_sd;
    int            occ;
    bit            nv [S];
    logic [DW-1:0] nd [S];
    #1;
    kmax = -1;
    for (int k = 0; k < S; k++) if (flush_req[k] && m_v[k]) kmax = k;
    take[S] = bus.out_ready;
    for (int i = S - 1; i >= 0; i--) take[i] = !m_v[i] || (stage_over[i] && take[i+1]);
    e_in_ready  = take[0] && (kmax < 0);
    e_out_valid = m_v[S-1] && stage_over[S-1];
    occ = 0;
    for (int i = 0; i < S; i++) begin
      e_sv[i] = m_v[i];
      e_ai[i] = take[i];
      e_sd[i*DW +: DW] = m_d[i];
      occ += int'(m_v[i]);
    end
    if (checking) begin
      chk("in_ready", bus.in_ready, e_in_ready);
      chk("out_valid", bus.out_valid, e_out_valid);
      chk("out_data", bus.out_data, m_d[S-1]);
      chk("stage_valid", stage_valid, e_sv);
      chk("stage_allow_in", stage_allow_in, e_ai);
      chk("stage_data", stage_data, e_sd);
      chk("occupancy", occupancy, occ);
      chk("retire_cnt", retire_cnt, m_ret);
      chk("stall_cnt", stall_cnt, m_stl);
      chk("flush_cnt", flush_cnt, m_fl);
    end
    for (int i = 0; i < S; i++) begin
      nv[i] = m_v[i];
      nd[i] = m_d[i];
    end
    for (int i = 0; i < S; i++) begin
      if (i < kmax) begin
        nv[i] = 1'b0;
      end else if (take[i]) begin
        if (i == 0) incoming = bus.in_valid && e_in_ready;
        else        incoming = m_v[i-1] && stage_over[i-1] && (i - 1 >= kmax);
        nv[i] = incoming;
        if (incoming) nd[i] = (i == 0) ? bus.in_data : m_d[i-1];
      end
    end
    if (e_out_valid && bus.out_ready) m_ret = m_ret + 1;
    if (bus.in_valid && !e_in_ready)  m_stl = m_stl + 1;
    if (kmax >= 0)                    m_fl  = m_fl + 1;
    for (int i = 0; i < S; i++) begin
      m_v[i] = nv[i];
      m_d[i] = nd[i];
    end
    if (reset) begin
      for (int i = 0; i < S; i++) begin
        m_v[i] = 1'b0;
        m_d[i] = '0;
      end
      m_ret = '0;
      m_stl = '0;
      m_fl  = '0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_ret;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    stage_over    = '1;
    flush_req     = '0;
    step();
    step();
    checking = 1'b1;
    reset = 1'b0;

    // streaming: one entry per cycle, first retire 5 cycles after first accept
    first_ret = -1;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      bus.in_data = 32'h100 + 32'(4 * n);
      #1;
      if (n == 0) chk("ready_after_reset", bus.in_ready, 1'b1);
      if (bus.out_valid && first_ret < 0) begin
        first_ret = n;
        chk("first_out_data", bus.out_data, 32'h100);
      end
      if (n == 15) chk("retire_after_10", retire_cnt, 10);
      step();
    end
    chk("first_retire_cycle", first_ret, 5);

    // stage 2 stalls for three cycles with the pipe full
    stage_over = 5'b11011;
    for (int n = 0; n < 3; n++) begin
      bus.in_data = 32'h200 + 32'(n);
      #1;
      chk("stall_in_ready", bus.in_ready, 1'b0);
      step();
    end
    stage_over = '1;
    #1;
    chk("stall_cnt_3", stall_cnt, 3);
    for (int n = 0; n < 3; n++) begin
      bus.in_data = 32'h300 + 32'(n);
      step();
    end

    // backpressure fills the pipe
    bus.out_ready = 1'b0;
    for (int n = 0; n < 8; n++) begin
      bus.in_data = 32'h400 + 32'(n);
      step();
    end
    #1;
    chk("bp_occupancy", occupancy, 5);
    chk("bp_in_ready", bus.in_ready, 1'b0);

    // single flush from the oldest stage, retire side still blocked
    flush_req = 5'b10000;
    #1;
    chk("flush_in_ready", bus.in_ready, 1'b0);
    step();
    flush_req = '0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_stage_valid", stage_valid, 5'b10000);
    chk("flush_cnt_1", flush_cnt, 1);

    // refill, then two flushers at once
    bus.in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      bus.in_data = 32'h500 + 32'(n);
      step();
    end
    chk("refill_full", stage_valid, 5'b11111);
    flush_req = 5'b01010;
    step();
    flush_req = '0;
    bus.in_valid = 1'b0;
    #1;
    chk("multi_stage_valid", stage_valid, 5'b11000);
    chk("multi_flush_cnt", flush_cnt, 2);
    flush_req = 5'b00100;
    step();
    flush_req = '0;
    #1;
    chk("ignored_flush_cnt", flush_cnt, 2);
    chk("ignored_stage_valid", stage_valid, 5'b11000);

    // reset in the middle of traffic
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int n = 0; n < 3; n++) begin
      bus.in_data = 32'h600 + 32'(n);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst_stage_valid", stage_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_retire_cnt", retire_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < S; i++) begin
        stage_over[i] = ($urandom_range(0, 4) != 0);
        flush_req[i]  = ($urandom_range(0, 49) == 0);
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised in-order pipeline control and payload-latching block. Successor to the hand-written five-stage valid/allow_in scheme in the CPU top.
- Holds one valid bit and one DATA_W payload register per stage. Generates per-stage allow_in from stage_over and downstream readiness.
- Adds output backpressure, per-stage flush of younger stages, occupancy reporting, and retire/stall/flush performance counters.
- Sits between the fetch source (in_*) and the retire/writeback consumer (out_*). Stage datapath logic stays outside and reports stage_over.

Parameters:
- STAGES, 5: number of register stages. Must be >= 2; elaboration error otherwise.
- DATA_W, 64: payload width per stage.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  new entry offered to stage 0.
- in_ready  out  1  stage 0 accepts this cycle.
- in_data  in  DATA_W  payload for stage 0.
- stage_over  in  STAGES  bit i: stage i work complete.
- flush_req  in  STAGES  bit k: stage k requests flush of all younger stages (index < k).
- stage_valid  out  STAGES  per-stage valid.
- stage_allow_in  out  STAGES  per-stage allow_in.
- stage_data  out  STAGES*DATA_W  payload registers; stage i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  last stage complete and presenting data.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  payload of stage STAGES-1.
- occupancy  out  $clog2(STAGES+1)  count of valid stages.
- retire_cnt  out  CNT_W  count of out_valid & out_ready cycles.
- stall_cnt  out  CNT_W  count of in_valid & ~in_ready cycles.
- flush_cnt  out  CNT_W  count of cycles with an effective flush.

Behaviour:
- Stage 0 is youngest; stage STAGES-1 is oldest and retires.
- Readiness chain:
  - allow_in[STAGES] := out_ready.
  - allow_in[i] = ~valid[i] | (stage_over[i] & valid[i] & allow_in[i+1]).
  - All purely combinational; no registered ready.
- Effective flush:
  - eff[k] = flush_req[k] & valid[k].
  - kmax = highest k with eff[k]; flush_req on an invalid stage is ignored.
  - Cleared set: stages 0..kmax-1. Stage kmax and older advance normally in the same cycle.
- in_ready = allow_in[0] & ~(any eff). No input is accepted in a flush cycle.
- Per-stage update each posedge:
  - If reset: valid[i]=0, data[i]=0.
  - Else if i < kmax (flush active): valid[i] <= 0; data unchanged.
  - Else if allow_in[i]:
    - valid[i] <= (i==0 ? in_valid & in_ready : valid[i-1] & stage_over[i-1]).
    - data[i] loads the incoming payload only when that incoming bit is 1.
  - Else hold.
- A stage handing off while stage i-1 is flushed: stage i receives a bubble (valid 0).
- out_valid = valid[STAGES-1] & stage_over[STAGES-1]; out_data = data[STAGES-1].
- Latency:
  - An entry accepted at edge t is in stage 0 after t.
  - With all stage_over and out_ready high it reaches stage STAGES-1 after t+STAGES-1 and retires at t+STAGES.
  - Throughput 1 per cycle.
- stage_over[i] is don't-care while valid[i]=0.
- occupancy is registered: the popcount of the next-state valid vector, so it matches stage_valid every cycle.
- Counters: increment by 1, wrap modulo 2^CNT_W, reset to 0. flush_cnt increments once per flush cycle, regardless of how many flush_req bits are set.
- Reset values: all valid, data, counters and occupancy are 0. Hence out_valid=0 and in_ready=1 in the cycle after reset deasserts.
- Reset asserted mid-operation wins over flush and advance. All in-flight entries are discarded without being counted as retired.

Decomposition:
- Shared header: PIPE_DATA_W_DEFAULT, PIPE_STAGES_DEFAULT, CNT_W_DEFAULT.
- Sub-module pipe_stage: one valid/data slice.
  - Inputs: clk, reset, kill, allow_in, in_bit, in_data.
  - Instantiated STAGES times in a generate loop.
- The allow_in chain, kmax priority encoder and counters live in pipe_ctrl.

Test Plan:
- Streaming (STAGES=5, DATA_W=32), all stage_over=1, out_ready=1:
  - Stimulus: in_data 0x100,0x104,... each cycle from reset release.
  - Response: out_valid first high 5 cycles after first acceptance with out_data=0x100, then one per cycle in order. retire_cnt=10 after 10 retires.
- Stage stall: stage_over[2]=0 for 3 cycles with pipe full.
  - Response: stages 0-2 hold and stage 3 gets bubbles. in_ready=0 during the stall, stall_cnt +=3. No lost or duplicated payloads.
- Backpressure: out_ready=0 while in_valid=1.
  - Response: occupancy reaches 5, in_ready=0, stall_cnt increments every cycle.
  - Release out_ready: retires 0x100 first.
- Flush: flush_req[4]=1 for one cycle with stages full.
  - Response: next cycle stage_valid=5'b10000 (stage 4 kept). Stages 0-3 cleared, in_ready=0 in the flush cycle, flush_cnt=1.
- Multi-flush: flush_req=5'b01010 with all valid.
  - Response: stages 0-2 cleared, stage 3 kept, flush_cnt +1 only.
  - flush_req[2]=1 with valid[2]=0: no effect and no count.
- Reset mid-stream: assert reset with 3 entries in flight.
  - Response: next cycle all valids, occupancy and counters are 0. No retire is counted, and in_ready=1 after deassert.
